// File: rtl/ycr1_pipe_mprf_wr_arb.sv
// Write-port arbiter and load scoreboard for the single-write-port MPRF.
// EXU, LSU and HDU share one registered write port; outstanding load destinations drive the rs busy flags.
module ycr1_pipe_mprf_wr_arb #(
  parameter int XLEN         = 32,
  parameter int AWIDTH       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_wr_vld_i,
  output logic              exu_wr_rdy_o,
  input  logic [AWIDTH-1:0] exu_wr_addr_i,
  input  logic [XLEN-1:0]   exu_wr_data_i,
  input  logic              lsu_wr_vld_i,
  output logic              lsu_wr_rdy_o,
  input  logic [AWIDTH-1:0] lsu_wr_addr_i,
  input  logic [XLEN-1:0]   lsu_wr_data_i,
  input  logic              dbg_wr_vld_i,
  output logic              dbg_wr_rdy_o,
  input  logic [AWIDTH-1:0] dbg_wr_addr_i,
  input  logic [XLEN-1:0]   dbg_wr_data_i,
  input  logic              ld_issue_i,
  input  logic [AWIDTH-1:0] ld_issue_addr_i,
  input  logic [AWIDTH-1:0] rs1_addr_i,
  input  logic [AWIDTH-1:0] rs2_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              mprf_w_req_o,
  output logic [AWIDTH-1:0] mprf_rd_addr_o,
  output logic [XLEN-1:0]   mprf_rd_data_o
);

  localparam int         NREG       = 2 ** AWIDTH;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt;
  logic              promote;
  logic              gnt_exu;
  logic              gnt_lsu;
  logic              gnt_dbg;
  logic              gnt_any;
  logic [AWIDTH-1:0] sel_addr;
  logic [XLEN-1:0]   sel_data;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  assign promote = (starve_cnt == STARVE_MAX);

  always_comb begin
    gnt_exu = 1'b0;
    gnt_lsu = 1'b0;
    gnt_dbg = 1'b0;
    if (!rst) begin
      if (promote && exu_wr_vld_i) gnt_exu = 1'b1;
      else if (dbg_wr_vld_i)       gnt_dbg = 1'b1;
      else if (lsu_wr_vld_i)       gnt_lsu = 1'b1;
      else if (exu_wr_vld_i)       gnt_exu = 1'b1;
    end
  end

  assign exu_wr_rdy_o = gnt_exu;
  assign lsu_wr_rdy_o = gnt_lsu;
  assign dbg_wr_rdy_o = gnt_dbg;
  assign gnt_any      = gnt_exu | gnt_lsu | gnt_dbg;

  always_comb begin
    sel_addr = exu_wr_addr_i;
    sel_data = exu_wr_data_i;
    if (gnt_dbg) begin
      sel_addr = dbg_wr_addr_i;
      sel_data = dbg_wr_data_i;
    end else if (gnt_lsu) begin
      sel_addr = lsu_wr_addr_i;
      sel_data = lsu_wr_data_i;
    end
  end

  // Set is applied after clear so a younger load to the same register wins
  always_comb begin
    busy_d = busy_q;
    if (gnt_lsu) busy_d[lsu_wr_addr_i] = 1'b0;
    if (ld_issue_i && (|ld_issue_addr_i)) busy_d[ld_issue_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt     <= '0;
      busy_q         <= '0;
      mprf_w_req_o   <= 1'b0;
      mprf_rd_addr_o <= '0;
      mprf_rd_data_o <= '0;
    end else begin
      if (exu_wr_vld_i && !gnt_exu)
        starve_cnt <= (starve_cnt >= STARVE_MAX) ? STARVE_MAX : starve_cnt + 4'd1;
      else
        starve_cnt <= '0;
      busy_q <= busy_d;
      // x0 writes are accepted but never reach the register file
      if (gnt_any && (|sel_addr)) begin
        mprf_w_req_o   <= 1'b1;
        mprf_rd_addr_o <= sel_addr;
        mprf_rd_data_o <= sel_data;
      end else begin
        mprf_w_req_o   <= 1'b0;
      end
    end
  end

  assign rs1_busy_o = (|rs1_addr_i) &&
                      (busy_q[rs1_addr_i] || (mprf_w_req_o && (mprf_rd_addr_o == rs1_addr_i)));
  assign rs2_busy_o = (|rs2_addr_i) &&
                      (busy_q[rs2_addr_i] || (mprf_w_req_o && (mprf_rd_addr_o == rs2_addr_i)));

  a_exu_hold: assert property (@(posedge clk) disable iff (rst)
    (exu_wr_vld_i && !exu_wr_rdy_o) |=> exu_wr_vld_i)
    else $error("exu_wr_vld_i dropped before acceptance");
  a_lsu_hold: assert property (@(posedge clk) disable iff (rst)
    (lsu_wr_vld_i && !lsu_wr_rdy_o) |=> lsu_wr_vld_i)
    else $error("lsu_wr_vld_i dropped before acceptance");
  a_dbg_hold: assert property (@(posedge clk) disable iff (rst)
    (dbg_wr_vld_i && !dbg_wr_rdy_o) |=> dbg_wr_vld_i)
    else $error("dbg_wr_vld_i dropped before acceptance");
  a_lsu_busy: assert property (@(posedge clk) disable iff (rst)
    (lsu_wr_vld_i && lsu_wr_rdy_o) |-> busy_q[lsu_wr_addr_i])
    else $error("LSU return to a register with no outstanding load");

endmodule

// File: tb/tb_ycr1_pipe_mprf_wr_arb.sv
// Self-checking bench for ycr1_pipe_mprf_wr_arb: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_ycr1_pipe_mprf_wr_arb;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int LIM  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          exu_vld, lsu_vld, dbg_vld;
  logic          exu_rdy, lsu_rdy, dbg_rdy;
  logic [AW-1:0] exu_addr, lsu_addr, dbg_addr;
  logic [31:0]   exu_data, lsu_data, dbg_data;
  logic          ld_issue;
  logic [AW-1:0] ld_addr, rs1, rs2;
  logic          rs1_busy, rs2_busy;
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_data;

  always #5 clk = ~clk;

  ycr1_pipe_mprf_wr_arb #(.XLEN(XLEN), .AWIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .exu_wr_vld_i(exu_vld), .exu_wr_rdy_o(exu_rdy), .exu_wr_addr_i(exu_addr), .exu_wr_data_i(exu_data),
    .lsu_wr_vld_i(lsu_vld), .lsu_wr_rdy_o(lsu_rdy), .lsu_wr_addr_i(lsu_addr), .lsu_wr_data_i(lsu_data),
    .dbg_wr_vld_i(dbg_vld), .dbg_wr_rdy_o(dbg_rdy), .dbg_wr_addr_i(dbg_addr), .dbg_wr_data_i(dbg_data),
    .ld_issue_i(ld_issue), .ld_issue_addr_i(ld_addr),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .mprf_w_req_o(w_req), .mprf_rd_addr_o(w_addr), .mprf_rd_data_o(w_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: consecutive EXU denials, outstanding-load set, pending write
  int          m_cnt;
  bit [31:0]   m_busy;
  bit          m_req;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          e_exu, e_lsu, e_dbg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_busy = '0;
    m_req  = 0;
    m_addr = '0;
    m_data = '0;
  endtask

  // one clock: check comb outputs mid-cycle, advance model at the edge, retire accepted requests
  task automatic cycle();
    bit          b1, b2;
    logic [4:0]  a;
    logic [31:0] d;
    #3;
    e_exu = 0; e_lsu = 0; e_dbg = 0;
    if (!rst) begin
      if (m_cnt == LIM && exu_vld) e_exu = 1;
      else if (dbg_vld)            e_dbg = 1;
      else if (lsu_vld)            e_lsu = 1;
      else if (exu_vld)            e_exu = 1;
    end
    b1 = (rs1 != 0) && (m_busy[rs1] || (m_req && m_addr == rs1));
    b2 = (rs2 != 0) && (m_busy[rs2] || (m_req && m_addr == rs2));
    chk("exu_rdy",   64'(exu_rdy),  64'(e_exu));
    chk("lsu_rdy",   64'(lsu_rdy),  64'(e_lsu));
    chk("dbg_rdy",   64'(dbg_rdy),  64'(e_dbg));
    chk("rs1_busy",  64'(rs1_busy), 64'(b1));
    chk("rs2_busy",  64'(rs2_busy), 64'(b2));
    chk("w_req",     64'(w_req),    64'(m_req));
    chk("w_addr",    64'(w_addr),   64'(m_addr));
    chk("w_data",    64'(w_data),   64'(m_data));
    @(posedge clk);
    if (rst) model_reset();
    else begin
      a = e_dbg ? dbg_addr : e_lsu ? lsu_addr : exu_addr;
      d = e_dbg ? dbg_data : e_lsu ? lsu_data : exu_data;
      if ((e_exu || e_lsu || e_dbg) && a != 0) begin
        m_req = 1; m_addr = a; m_data = d;
      end else m_req = 0;
      if (exu_vld && !e_exu) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
      else m_cnt = 0;
      if (e_lsu) m_busy[lsu_addr] = 0;
      if (ld_issue && ld_addr != 0) m_busy[ld_addr] = 1;
    end
    #1;
    if (e_exu) exu_vld = 0;
    if (e_lsu) lsu_vld = 0;
    if (e_dbg) dbg_vld = 0;
    ld_issue = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (exu_vld || lsu_vld || dbg_vld); i++) cycle();
    chk("drain_timeout", 64'(exu_vld || lsu_vld || dbg_vld), 64'(0));
  endtask

  task automatic load(input logic [4:0] a);
    ld_issue = 1; ld_addr = a;
    cycle();
  endtask

  initial begin
    int denied, nxt, idx;
    bit got;
    rst = 1;
    exu_vld = 0; lsu_vld = 0; dbg_vld = 0; ld_issue = 0;
    exu_addr = '0; lsu_addr = '0; dbg_addr = '0; ld_addr = '0;
    exu_data = '0; lsu_data = '0; dbg_data = '0; rs1 = '0; rs2 = '0;
    @(posedge clk); #1;
    model_reset();
    cycle();
    rst = 0;

    // EXU alone: one-cycle latency to the write port
    exu_vld = 1; exu_addr = 5; exu_data = 32'hA5A5_0001;
    cycle();
    chk("t1_req",  64'(w_req), 64'(1));
    chk("t1_addr", 64'(w_addr), 64'(5));
    chk("t1_data", 64'(w_data), 64'hA5A5_0001);
    cycle();
    chk("t1_idle", 64'(w_req), 64'(0));

    // three-way contention
    load(2);
    dbg_vld = 1; dbg_addr = 1; dbg_data = 32'h1111;
    lsu_vld = 1; lsu_addr = 2; lsu_data = 32'h2222;
    exu_vld = 1; exu_addr = 3; exu_data = 32'h3333;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk("t2_order", 64'(w_addr), 64'(k));
    end
    cycle();

    // starvation promotion
    for (int k = 10; k <= 14; k++) load(5'(k));
    exu_vld = 1; exu_addr = 6; exu_data = 32'h6666;
    lsu_vld = 1; lsu_addr = 10; lsu_data = 32'hAAAA;
    nxt = 11; denied = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (e_exu) got = 1; else denied++;
      if (!lsu_vld && nxt <= 14) begin lsu_vld = 1; lsu_addr = 5'(nxt); nxt++; end
    end
    chk("t3_granted", 64'(got), 64'(1));
    chk("t3_denied", 64'(denied), 64'(LIM));
    drain();

    // scoreboard window for x7
    rs1 = 7;
    load(7);
    chk("t4_busy_set", 64'(rs1_busy), 64'(1));
    cycle();
    lsu_vld = 1; lsu_addr = 7; lsu_data = 32'h7777;
    cycle();
    chk("t4_busy_window", 64'(rs1_busy), 64'(1));
    cycle();
    chk("t4_busy_clear", 64'(rs1_busy), 64'(0));

    // same-cycle set and clear: set wins
    rs1 = 9;
    load(9);
    lsu_vld = 1; lsu_addr = 9; lsu_data = 32'h9999;
    ld_issue = 1; ld_addr = 9;
    cycle();
    cycle();
    chk("t5_set_wins", 64'(rs1_busy), 64'(1));
    rs2 = 0;
    load(0);

    // x0 write and reset with a write pending
    exu_vld = 1; exu_addr = 0; exu_data = 32'hDEAD;
    cycle();
    chk("t6_x0_noreq", 64'(w_req), 64'(0));
    rs1 = 4;
    load(4);
    lsu_vld = 1; lsu_addr = 4; lsu_data = 32'h4444;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("t6_rst_req", 64'(w_req), 64'(0));
    chk("t6_rst_busy", 64'(rs1_busy), 64'(0));
    cycle();

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(63) == 0) begin
        rst = 1; exu_vld = 0; lsu_vld = 0; dbg_vld = 0;
      end else begin
        rst = 0;
        if (!exu_vld && $urandom_range(1) == 1) begin
          exu_vld = 1; exu_addr = 5'($urandom); exu_data = $urandom;
        end
        if (!dbg_vld && $urandom_range(3) == 0) begin
          dbg_vld = 1; dbg_addr = 5'($urandom); dbg_data = $urandom;
        end
        if (!lsu_vld && m_busy != 0 && $urandom_range(1) == 1) begin
          idx = $urandom_range(31);
          while (!m_busy[idx]) idx = (idx + 1) % 32;
          lsu_vld = 1; lsu_addr = 5'(idx); lsu_data = $urandom;
        end
        ld_issue = ($urandom_range(2) == 0);
        ld_addr  = 5'($urandom);
      end
      rs1 = ($urandom_range(1) == 1) ? m_addr : 5'($urandom);
      rs2 = 5'($urandom);
      cycle();
    end
    rst = 0;
    exu_vld = 0; lsu_vld = 0; dbg_vld = 0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
